// File: rtl/rv32i_types.sv
// Shared RV32I front-end types.
// Holds the instruction-queue entry layout and the branch-tag width that the
// branch-tag logic also uses.
package rv32i_types;

  localparam int BID_W    = 3;  // branch tag width
  localparam int IQ_DEPTH = 8;  // default instruction-queue depth

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [BID_W-1:0] branch_id;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between the I-cache response path and the fetch
// stage instruction register. Each entry carries {instr, pc, branch_id}.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop all entries; beats an enqueue in the same cycle
//   enq_valid/ready  producer handshake; enq_instr/pc/branch_id payload
//   deq_valid/ready  consumer handshake; deq_instr/pc/branch_id show the head
//                    entry, or zero when empty
//   count            number of occupied entries
module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int BID_W = rv32i_types::BID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [31:0]              enq_instr,
  input  logic [31:0]              enq_pc,
  input  logic [BID_W-1:0]         enq_branch_id,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [31:0]              deq_pc,
  output logic [BID_W-1:0]         deq_branch_id,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t        mem [DEPTH];
  iq_entry_t        head_entry;
  logic [PTR_W-1:0] head, tail;
  logic             enq_fire, deq_fire;

  // Handshakes depend only on occupancy: a full queue never accepts in the
  // same cycle as a dequeue, which keeps enq_ready off the deq_ready path.
  always_comb begin
    enq_ready  = (count != CNT_W'(DEPTH));
    deq_valid  = (count != '0);
    enq_fire   = enq_valid && enq_ready && !flush;
    deq_fire   = deq_valid && deq_ready;
    head_entry = mem[head];
    deq_instr     = '0;
    deq_pc        = '0;
    deq_branch_id = '0;
    if (deq_valid) begin
      deq_instr     = head_entry.instr;
      deq_pc        = head_entry.pc;
      deq_branch_id = head_entry.branch_id;
    end
  end

  // Storage is not reset; only slots below count are ever read out.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire)
      mem[tail] <= '{instr: enq_instr, pc: enq_pc, branch_id: enq_branch_id};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // A dequeue in a flush cycle still reaches the consumer; the queue
      // simply forgets everything afterwards.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue. Inputs change and outputs are sampled 1ns
// after the rising edge.
module tb_instr_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid, deq_ready;
  logic        enq_ready, deq_valid;
  logic [31:0] enq_instr, enq_pc, deq_instr, deq_pc;
  logic [2:0]  enq_branch_id, deq_branch_id;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  instr_queue #(.DEPTH(8), .BID_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_branch_id(enq_branch_id),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_branch_id(deq_branch_id),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] instr);
    enq_valid     = v;
    enq_instr     = instr;
    enq_pc        = {instr[29:0], 2'b00};
    enq_branch_id = instr[2:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({deq_valid, enq_ready, count, deq_instr} !== {1'b0, 1'b1, 4'd0, 32'h0}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got v=%b r=%b cnt=%0d instr=%h want v=0 r=1 cnt=0 instr=0",
                 i, deq_valid, enq_ready, count, deq_instr);
      end
      tick();
    end
  endtask

  task automatic test_single();
    // deq_ready held high while empty must be ignored
    deq_ready = 1'b1;
    enq_valid = 1'b1; enq_instr = 32'h00500093; enq_pc = 32'h60; enq_branch_id = 3'd2;
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    checks++;
    if ({deq_valid, count, deq_instr, deq_pc, deq_branch_id} !==
        {1'b1, 4'd1, 32'h00500093, 32'h60, 3'd2}) begin
      errors++;
      $display("FAIL single_enq: got v=%b cnt=%0d instr=%h pc=%h bid=%0d want v=1 cnt=1 instr=00500093 pc=60 bid=2",
               deq_valid, count, deq_instr, deq_pc, deq_branch_id);
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    checks++;
    if ({deq_valid, count, deq_instr} !== {1'b0, 4'd0, 32'h0}) begin
      errors++;
      $display("FAIL single_deq: got v=%b cnt=%0d instr=%h want v=0 cnt=0 instr=0",
               deq_valid, count, deq_instr);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, 32'h1000 + i);
      tick();
    end
    set_enq(1'b0, 32'h0);
    checks++;
    if ({count, enq_ready} !== {4'd8, 1'b0}) begin
      errors++;
      $display("FAIL full: got cnt=%0d r=%b want cnt=8 r=0", count, enq_ready);
    end
    // dequeue 3; the first one also offers a 9th word that must be refused
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_enq(1'b1, 32'hDEAD);
      deq_ready = 1'b1;
      checks++;
      if ({deq_instr, deq_pc} !== {32'h1000 + i, (32'h1000 + i) << 2}) begin
        errors++;
        $display("FAIL full_deq%0d: got instr=%h pc=%h want %h", i, deq_instr, deq_pc, 32'h1000 + i);
      end
      if (i == 0) begin
        checks++;
        if (enq_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_enq_ready_with_deq: got %b want 0", enq_ready);
        end
      end
      tick();
      set_enq(1'b0, 32'h0);
    end
    deq_ready = 1'b0;
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL after_deq3_count: got %0d want 5", count);
    end
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h1008 + i);
      tick();
    end
    set_enq(1'b0, 32'h0);
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({deq_valid, deq_instr, deq_branch_id} !== {1'b1, 32'h1003 + i, 3'(32'h1003 + i)}) begin
        errors++;
        $display("FAIL wrap_drain%0d: got v=%b instr=%h bid=%0d want instr=%h",
                 i, deq_valid, deq_instr, deq_branch_id, 32'h1003 + i);
      end
      tick();
    end
    deq_ready = 1'b0;
    checks++;
    if ({deq_valid, count} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL wrap_empty: got v=%b cnt=%0d want v=0 cnt=0", deq_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'h2000 + i);
      tick();
    end
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 32'h2004 + i);
      checks++;
      if ({count, deq_instr} !== {4'd4, 32'h2000 + i}) begin
        errors++;
        $display("FAIL b2b%0d: got cnt=%0d instr=%h want cnt=4 instr=%h",
                 i, count, deq_instr, 32'h2000 + i);
      end
      tick();
    end
    set_enq(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (deq_instr !== 32'h200A + i) begin
        errors++;
        $display("FAIL b2b_drain%0d: got %h want %h", i, deq_instr, 32'h200A + i);
      end
      tick();
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_enq(1'b1, 32'h3000 + i);
      tick();
    end
    flush = 1'b1;
    set_enq(1'b1, 32'hBAD);
    deq_ready = 1'b1;
    // the head still transfers to the consumer in the flush cycle
    checks++;
    if ({deq_valid, deq_instr} !== {1'b1, 32'h3000}) begin
      errors++;
      $display("FAIL flush_cycle_deq: got v=%b instr=%h want v=1 instr=00003000", deq_valid, deq_instr);
    end
    tick();
    flush = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    checks++;
    if ({count, deq_valid, deq_instr} !== {4'd0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d v=%b instr=%h want cnt=0 v=0 instr=0",
               count, deq_valid, deq_instr);
    end
    set_enq(1'b1, 32'h3100);
    tick();
    set_enq(1'b0, 32'h0);
    checks++;
    if ({count, deq_instr} !== {4'd1, 32'h3100}) begin
      errors++;
      $display("FAIL flush_next_enq: got cnt=%0d instr=%h want cnt=1 instr=00003100", count, deq_instr);
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h4000 + i);
      tick();
    end
    rst = 1'b1; deq_ready = 1'b1;
    set_enq(1'b1, 32'h4003);
    tick();
    rst = 1'b0; deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    checks++;
    if ({count, enq_ready, deq_valid, deq_instr, deq_pc, deq_branch_id} !==
        {4'd0, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%0d r=%b v=%b instr=%h pc=%h bid=%0d want all idle/zero",
               count, enq_ready, deq_valid, deq_instr, deq_pc, deq_branch_id);
    end
    set_enq(1'b1, 32'h4100);
    tick();
    set_enq(1'b0, 32'h0);
    checks++;
    if ({count, deq_instr} !== {4'd1, 32'h4100}) begin
      errors++;
      $display("FAIL post_reset_enq: got cnt=%0d instr=%h want cnt=1 instr=00004100", count, deq_instr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
